id2_operand_stage: RTL
======================

ID2_OPERAND_STAGE -- requirements
Module: id2_operand_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have parameter FWD_NUM, default 5, number of forwarding sources (1..7).
REQ-003 SHALL have parameter CTRL_W, default 24, width of the opaque decoded-control bundle.
REQ-004 SHALL have ports:
 clk  in  1  clock, all state on rising edge
 rst_n  in  1  asynchronous active-low reset
 in_valid  in  1  ID1 instruction present
 in_ready  out  1  stage accepts this cycle
 in_pc  in  32  instruction PC
 in_op_code  in  6  opcode
 in_rs / in_rt  in  5 each  source register addresses
 in_imme  in  16  immediate
 in_j_imme  in  26  jump index
 in_is_branch / in_is_j_imme / in_is_jr  in  1 each  control-transfer class
 in_ctrl  in  CTRL_W  decoded controls, passed through
 fwd_sel_rs / fwd_sel_rt  in  3 each  0 = regfile, k = forwarding source k
 fwd_data  in  FWD_NUM*32  forwarding data, source k at bits [32k-1:32(k-1)]
 fwd_ready  in  FWD_NUM  source k data valid this cycle
 reg_r_addr_1 / reg_r_addr_2  out  5 each  equal to in_rs / in_rt
 reg_r_data_1 / reg_r_data_2  in  32 each  regfile read data
 flush  in  1  squash from a later stage
 out_valid  out  1  registered instruction valid
 out_ready  in  1  EX stage accepts
 out_pc, out_rs_data, out_rt_data, out_ext_imme  out  32 each  registered operands
 out_ctrl  out  CTRL_W  registered in_ctrl
 redirect_valid  out  1  one-cycle fetch-redirect pulse
 redirect_pc  out  32  redirect target
 stall_cnt  out  32  operand-hazard stall cycles

Function
REQ-005 SHALL select rs/rt operands from the regfile (sel 0) or fwd_data source sel; sel > FWD_NUM SHALL return 0.
REQ-006 SHALL assert hazard when a nonzero sel names a source whose fwd_ready is 0.
REQ-007 SHALL drive in_ready = (!out_valid | out_ready) & !hazard & !flush.
REQ-008 SHALL capture all out_* registers on accept (in_valid & in_ready); latency exactly 1 cycle.
REQ-009 SHALL hold out_* stable while out_valid & !out_ready.
REQ-010 SHALL clear out_valid when out_ready is high and there is no accept.
REQ-011 SHALL sign-extend in_imme for ADDI, ADDIU, SLTI, SLTIU and all loads/stores, and zero-extend otherwise.
REQ-012 SHALL resolve BEQ, BNE, BGEZ, BGTZ, BLEZ, BLTZ, BGEZAL, BLTZAL; REGIMM subtype is decoded from in_rt; comparisons are signed.
REQ-013 SHALL compute targets: branch pc+4+(sext(imme)<<2); J/JAL {pc+4[31:28],j_imme,2'b00}; JR/JALR rs operand; all arithmetic mod 2^32.
REQ-014 SHALL pulse redirect_valid for exactly one cycle, the cycle after accepting a taken transfer, with redirect_pc registered.
REQ-015 flush SHALL clear out_valid and suppress redirect_valid on the next edge; flush coincident with in_valid is not an accept (flush wins).
REQ-016 stall_cnt SHALL increment each cycle in which in_valid & hazard & !flush, saturating at 32'hFFFF_FFFF.

Reset
REQ-017 rst_n low SHALL asynchronously clear out_valid, redirect_valid and stall_cnt, and all data registers including redirect_pc, to 0.
REQ-018 After release mid-stream, the first accept SHALL occur no earlier than the first rising edge with rst_n high.

Configuration
REQ-019 With BRANCH_LIKELY_EN defined, SHALL additionally resolve BEQL, BNEL, BGTZL, BLEZL, and on a not-taken likely branch accepted, SHALL squash the next accepted instruction (delay slot) by not setting out_valid for it.
REQ-020 Without BRANCH_LIKELY_EN, likely opcodes SHALL be treated as non-branch; no squash logic is present.

Structure
REQ-021 Opcode, REGIMM rt codes and forward-select encodings SHALL live in the shared decode package/header with the existing op-code definitions.
REQ-022 Branch compare and target generation SHALL be one combinational sub-module, br_resolve.

Verification
REQ-023 BEQ pc=0x100, imme=0x0004, rs=rt=7 via regfile -> redirect_valid pulse 1 cycle after accept, redirect_pc=0x114.
REQ-024 fwd_sel_rs=2 with fwd_ready[1]=0 for 3 cycles, then 1 -> in_ready low for 3 cycles, stall_cnt=3, operand = fwd_data source 2.
REQ-025 out_ready low for 4 cycles with out_valid=1 -> out_* unchanged, in_ready=0.
REQ-026 JR accepted with flush asserted in the same cycle -> no accept, out_valid=0, no redirect.
REQ-027 rst_n pulsed low mid-stall with stall_cnt=9 -> all outputs 0 immediately, stall_cnt=0.
REQ-028 BRANCH_LIKELY_EN defined: BNEL with rs=rt, followed by ADDIU -> no redirect, ADDIU not presented (out_valid stays 0).

Source files
------------

// File: rtl/id2_operand_stage_pkg.sv
// Shared decode definitions for the ID2 operand stage: MIPS opcodes,
// REGIMM rt subtypes, forward-select encodings and immediate-extension helper.
package id2_operand_stage_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_BEQL    = 6'h14;
  localparam logic [5:0] OP_BNEL    = 6'h15;
  localparam logic [5:0] OP_BLEZL   = 6'h16;
  localparam logic [5:0] OP_BGTZL   = 6'h17;

  // REGIMM branch subtype carried in the rt field
  typedef enum logic [4:0] {
    RT_BLTZ   = 5'h00,
    RT_BGEZ   = 5'h01,
    RT_BLTZAL = 5'h10,
    RT_BGEZAL = 5'h11
  } regimm_rt_e;

  // Operand select: 0 reads the regfile, k picks forwarding source k
  localparam logic [2:0] FWD_SEL_RF = 3'd0;

  // Arithmetic/compare immediates and every load/store (opcode 1xxxxx) sign-extend
  function automatic logic imm_is_signed(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) ||
           (op == OP_SLTIU) || op[5];
  endfunction

endpackage

// File: rtl/id2_operand_stage_br_resolve.sv
// br_resolve: combinational branch compare and control-transfer target.
// BRANCH_LIKELY_EN adds the BEQL/BNEL/BLEZL/BGTZL opcodes and a likely flag.
module br_resolve
  import id2_operand_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        op_code_i,
  input  logic [4:0]        rt_addr_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [15:0]       imme_i,
  input  logic [25:0]       j_imme_i,
  input  logic              is_branch_i,
  input  logic              is_j_imme_i,
  input  logic              is_jr_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
`ifdef BRANCH_LIKELY_EN
  output logic              likely_o,
`endif
  output logic              taken_o,
  output logic [DATA_W-1:0] target_o
);

  logic signed [DATA_W-1:0] rs_s;
  logic                     rs_neg, rs_zero, rs_eq_rt, cond;
  logic [DATA_W-1:0]        pc4, br_ofs;

  assign rs_s     = rs_data_i;
  assign rs_neg   = rs_s[DATA_W-1];
  assign rs_zero  = (rs_data_i == '0);
  assign rs_eq_rt = (rs_data_i == rt_data_i);
  assign pc4      = pc_i + DATA_W'(4);
  assign br_ofs   = {{(DATA_W-18){imme_i[15]}}, imme_i, 2'b00};

  // Signed condition evaluation per branch opcode
  always_comb begin
    cond = 1'b0;
`ifdef BRANCH_LIKELY_EN
    likely_o = 1'b0;
`endif
    case (op_code_i)
      OP_BEQ:  cond = rs_eq_rt;
      OP_BNE:  cond = !rs_eq_rt;
      OP_BLEZ: cond = rs_neg || rs_zero;
      OP_BGTZ: cond = !rs_neg && !rs_zero;
      OP_REGIMM: begin
        case (rt_addr_i)
          RT_BLTZ, RT_BLTZAL: cond = rs_neg;
          RT_BGEZ, RT_BGEZAL: cond = !rs_neg;
          default:            cond = 1'b0;
        endcase
      end
`ifdef BRANCH_LIKELY_EN
      OP_BEQL:  begin cond = rs_eq_rt;              likely_o = is_branch_i; end
      OP_BNEL:  begin cond = !rs_eq_rt;             likely_o = is_branch_i; end
      OP_BLEZL: begin cond = rs_neg || rs_zero;     likely_o = is_branch_i; end
      OP_BGTZL: begin cond = !rs_neg && !rs_zero;   likely_o = is_branch_i; end
`endif
      default: cond = 1'b0;
    endcase
  end

  assign taken_o  = is_jr_i || is_j_imme_i || (is_branch_i && cond);
  assign target_o = is_jr_i     ? rs_data_i :
                    is_j_imme_i ? {pc4[DATA_W-1:DATA_W-4], j_imme_i, 2'b00} :
                                  pc4 + br_ofs;

endmodule

// File: rtl/id2_operand_stage.sv
// id2_operand_stage: operand select/forwarding, immediate extension, branch
// resolution and a one-deep output register toward EX.
// Optional feature macro: BRANCH_LIKELY_EN (likely branches + delay-slot squash).
module id2_operand_stage
  import id2_operand_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int FWD_NUM = 5,
  parameter int CTRL_W  = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_pc,
  input  logic [5:0]              in_op_code,
  input  logic [4:0]              in_rs,
  input  logic [4:0]              in_rt,
  input  logic [15:0]             in_imme,
  input  logic [25:0]             in_j_imme,
  input  logic                    in_is_branch,
  input  logic                    in_is_j_imme,
  input  logic                    in_is_jr,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [2:0]              fwd_sel_rs,
  input  logic [2:0]              fwd_sel_rt,
  input  logic [FWD_NUM*32-1:0]   fwd_data,
  input  logic [FWD_NUM-1:0]      fwd_ready,
  output logic [4:0]              reg_r_addr_1,
  output logic [4:0]              reg_r_addr_2,
  input  logic [DATA_W-1:0]       reg_r_data_1,
  input  logic [DATA_W-1:0]       reg_r_data_2,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_pc,
  output logic [DATA_W-1:0]       out_rs_data,
  output logic [DATA_W-1:0]       out_rt_data,
  output logic [DATA_W-1:0]       out_ext_imme,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic                    redirect_valid,
  output logic [DATA_W-1:0]       redirect_pc,
  output logic [31:0]             stall_cnt
);

  // Pick regfile data or forwarding source sel; out-of-range sources read 0
  function automatic logic [DATA_W-1:0] fwd_pick(input logic [2:0] sel,
                                                 input logic [DATA_W-1:0] rf,
                                                 input logic [FWD_NUM*32-1:0] fd);
    logic [DATA_W-1:0] r;
    r = '0;
    if (sel == FWD_SEL_RF) r = rf;
    for (int k = 1; k <= FWD_NUM; k++)
      if (sel == 3'(k)) r = fd[32*(k-1) +: 32];
    return r;
  endfunction

  // A named forwarding source that has not produced its data yet
  function automatic logic fwd_wait(input logic [2:0] sel, input logic [FWD_NUM-1:0] rdy);
    logic w;
    w = 1'b0;
    for (int k = 1; k <= FWD_NUM; k++)
      if (sel == 3'(k)) w = !rdy[k-1];
    return w;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic              hazard, accept, present, br_taken;
  logic [DATA_W-1:0] rs_opnd, rt_opnd, ext_imme, br_target;
  logic              out_valid_q, out_valid_d, redirect_valid_q, redirect_valid_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;
  logic [DATA_W-1:0] out_pc_q, out_rs_q, out_rt_q, out_imm_q, redirect_pc_q;
  logic [CTRL_W-1:0] out_ctrl_q;

  assign reg_r_addr_1 = in_rs;
  assign reg_r_addr_2 = in_rt;
  assign rs_opnd  = fwd_pick(fwd_sel_rs, reg_r_data_1, fwd_data);
  assign rt_opnd  = fwd_pick(fwd_sel_rt, reg_r_data_2, fwd_data);
  assign hazard   = fwd_wait(fwd_sel_rs, fwd_ready) || fwd_wait(fwd_sel_rt, fwd_ready);
  assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  assign ext_imme = imm_is_signed(in_op_code) ? {{(DATA_W-16){in_imme[15]}}, in_imme}
                                              : {{(DATA_W-16){1'b0}}, in_imme};

`ifdef BRANCH_LIKELY_EN
  logic br_likely, squash_q, squash_d;
`endif

  br_resolve #(.DATA_W(DATA_W)) u_br_resolve (
    .op_code_i   (in_op_code),
    .rt_addr_i   (in_rt),
    .pc_i        (in_pc),
    .imme_i      (in_imme),
    .j_imme_i    (in_j_imme),
    .is_branch_i (in_is_branch),
    .is_j_imme_i (in_is_j_imme),
    .is_jr_i     (in_is_jr),
    .rs_data_i   (rs_opnd),
    .rt_data_i   (rt_opnd),
`ifdef BRANCH_LIKELY_EN
    .likely_o    (br_likely),
`endif
    .taken_o     (br_taken),
    .target_o    (br_target)
  );

`ifdef BRANCH_LIKELY_EN
  // A not-taken likely branch kills the next accepted instruction (its delay slot)
  assign present = !squash_q;
  always_comb begin
    squash_d = squash_q;
    if (flush)       squash_d = 1'b0;
    else if (accept) squash_d = present && br_likely && !br_taken;
  end

  // Pending delay-slot squash
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) squash_q <= 1'b0;
    else        squash_q <= squash_d;
  end
`else
  assign present = 1'b1;
`endif

  // Next-state for valid, redirect pulse and the hazard-stall counter
  always_comb begin
    out_valid_d      = out_valid_q;
    redirect_valid_d = 1'b0;
    if (flush)          out_valid_d = 1'b0;
    else if (accept)    out_valid_d = present;
    else if (out_ready) out_valid_d = 1'b0;
    if (accept && present && br_taken) redirect_valid_d = 1'b1;
    stall_cnt_d = (in_valid && hazard && !flush) ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q      <= 1'b0;
      redirect_valid_q <= 1'b0;
      stall_cnt_q      <= '0;
    end else begin
      out_valid_q      <= out_valid_d;
      redirect_valid_q <= redirect_valid_d;
      stall_cnt_q      <= stall_cnt_d;
    end
  end

  // Operand/data registers: loaded only on accept so they hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_pc_q      <= '0;
      out_rs_q      <= '0;
      out_rt_q      <= '0;
      out_imm_q     <= '0;
      out_ctrl_q    <= '0;
      redirect_pc_q <= '0;
    end else if (accept) begin
      out_pc_q   <= in_pc;
      out_rs_q   <= rs_opnd;
      out_rt_q   <= rt_opnd;
      out_imm_q  <= ext_imme;
      out_ctrl_q <= in_ctrl;
      if (present && br_taken) redirect_pc_q <= br_target;
    end
  end

  assign out_valid      = out_valid_q;
  assign redirect_valid = redirect_valid_q;
  assign stall_cnt      = stall_cnt_q;
  assign out_pc         = out_pc_q;
  assign out_rs_data    = out_rs_q;
  assign out_rt_data    = out_rt_q;
  assign out_ext_imme   = out_imm_q;
  assign out_ctrl       = out_ctrl_q;
  assign redirect_pc    = redirect_pc_q;

endmodule
